// File: rtl/debug_step_ctrl.sv
// UART-driven single-step and register-dump controller: 'S' steps the pipeline once then dumps,
// 'D' dumps only. Optional dump header (0xA5, step count) is enabled by DBG_DUMP_HEADER_EN.
module debug_step_ctrl #(
  parameter int NUM_WORDS  = 34,
  parameter int SETTLE_CYC = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_data_rdy,
  output logic        step_en,
  output logic [5:0]  word_sel,
  input  logic [31:0] word_data,
  output logic [7:0]  fifo_din,
  output logic        fifo_wr_en,
  input  logic        fifo_full,
  output logic        busy,
  output logic        dump_done,
  output logic [2:0]  dbg_state
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_STEP   = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_LOAD   = 3'd3;
  localparam logic [2:0] ST_SEND   = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;
  localparam logic [2:0] ST_HDR    = 3'd6;

  localparam logic [5:0] LAST_WORD   = 6'(NUM_WORDS - 1);
  localparam logic [3:0] LAST_SETTLE = 4'(SETTLE_CYC - 1);

`ifdef DBG_DUMP_HEADER_EN
  localparam logic [2:0] ST_PRELOAD = ST_HDR;
`else
  localparam logic [2:0] ST_PRELOAD = ST_LOAD;
`endif

  // Handshake: a command byte is consumed only on a cycle where rx_data_rdy=1 and
  // the block is idle; a FIFO byte is transferred on any cycle with fifo_wr_en=1,
  // and fifo_wr_en is never raised while fifo_full=1.
  logic [2:0]  state, state_nxt;
  logic [5:0]  word_idx;
  logic [1:0]  byte_idx;
  logic [3:0]  settle_cnt;
  logic [31:0] shadow;
  logic        cmd_s, cmd_d;

  assign cmd_s = rx_data_rdy && (rx_data == 8'h53);
  assign cmd_d = rx_data_rdy && (rx_data == 8'h44);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (cmd_s)      state_nxt = ST_STEP;
        else if (cmd_d) state_nxt = ST_PRELOAD;
      end
      ST_STEP:   state_nxt = ST_SETTLE;
      ST_SETTLE: if (settle_cnt == LAST_SETTLE) state_nxt = ST_PRELOAD;
      ST_HDR:    if (!fifo_full && byte_idx[0]) state_nxt = ST_LOAD;
      ST_LOAD:   state_nxt = ST_SEND;
      ST_SEND: begin
        if (!fifo_full && (byte_idx == 2'd3))
          state_nxt = (word_idx == LAST_WORD) ? ST_DONE : ST_LOAD;
      end
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      word_idx   <= 6'd0;
      byte_idx   <= 2'd0;
      settle_cnt <= 4'd0;
      shadow     <= 32'd0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE:   byte_idx <= 2'd0;
        ST_STEP: begin
          settle_cnt <= 4'd0;
          byte_idx   <= 2'd0;
        end
        ST_SETTLE: settle_cnt <= settle_cnt + 4'd1;
        ST_HDR:    if (!fifo_full) byte_idx <= byte_idx + 2'd1;
        ST_LOAD: begin
          shadow   <= word_data;
          byte_idx <= 2'd0;
        end
        ST_SEND: begin
          if (!fifo_full) begin
            byte_idx <= byte_idx + 2'd1;
            if ((byte_idx == 2'd3) && (word_idx != LAST_WORD))
              word_idx <= word_idx + 6'd1;
          end
        end
        default: ;
      endcase
      // Only the first LOAD of a dump restarts the word index; word_sel holds otherwise.
      if ((state_nxt == ST_LOAD) && (state != ST_SEND))
        word_idx <= 6'd0;
    end
  end

`ifdef DBG_DUMP_HEADER_EN
  logic [7:0] step_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                step_cnt <= 8'd0;
    else if (state == ST_STEP) step_cnt <= step_cnt + 8'd1;
  end
`endif

  always_comb begin
    fifo_din = 8'h00;
    if (state == ST_SEND) begin
      case (byte_idx)
        2'd0:    fifo_din = shadow[7:0];
        2'd1:    fifo_din = shadow[15:8];
        2'd2:    fifo_din = shadow[23:16];
        default: fifo_din = shadow[31:24];
      endcase
    end
`ifdef DBG_DUMP_HEADER_EN
    else if (state == ST_HDR) begin
      fifo_din = byte_idx[0] ? step_cnt : 8'hA5;
    end
`endif
  end

  assign fifo_wr_en = ((state == ST_SEND) || (state == ST_HDR)) && !fifo_full;
  assign step_en    = (state == ST_STEP);
  assign busy       = (state != ST_IDLE);
  assign dump_done  = (state == ST_DONE);
  assign word_sel   = word_idx;
  assign dbg_state  = state;

endmodule

// File: tb/tb_debug_step_ctrl.sv
// Bench for debug_step_ctrl: directed and randomized commands, byte-stream scoreboard
// built from a word table, timing and reset checks.
module tb_debug_step_ctrl;
  localparam int NW = 34;
  localparam int SC = 2;
`ifdef DBG_DUMP_HEADER_EN
  localparam int HDR = 2;
`else
  localparam int HDR = 0;
`endif
  localparam int PUSH_OFS = (HDR > 0) ? 0 : 1;
  localparam int LOAD_OFS = (HDR > 0) ? 2 : -1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_data_rdy;
  logic        step_en;
  logic [5:0]  word_sel;
  logic [31:0] word_data;
  logic [7:0]  fifo_din;
  logic        fifo_wr_en;
  logic        fifo_full;
  logic        busy;
  logic        dump_done;
  logic [2:0]  dbg_state;

  logic [31:0] mem [0:63];
  assign word_data = mem[word_sel];

  debug_step_ctrl #(.NUM_WORDS(NW), .SETTLE_CYC(SC)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_data_rdy(rx_data_rdy),
    .step_en(step_en), .word_sel(word_sel), .word_data(word_data),
    .fifo_din(fifo_din), .fifo_wr_en(fifo_wr_en), .fifo_full(fifo_full),
    .busy(busy), .dump_done(dump_done), .dbg_state(dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  int tests_run = 0;
  int tests_failed = 0;
  logic [7:0] exp_q[$];
  int pushes, steps_seen, dones_seen;
  int first_push_cyc, step_cyc, done_cyc;
  int steps_model = 0;
  bit rand_stall = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (fifo_full) check("wr_while_full", 32'(fifo_wr_en), 32'd0);
      if (busy) check("word_sel_range", 32'(word_sel < NW), 32'd1);
      if (fifo_wr_en) begin
        if (pushes == 0) first_push_cyc = cyc;
        pushes++;
        check("byte_available", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) check("byte_value", 32'(fifo_din), 32'(exp_q.pop_front()));
      end
      if (step_en) begin
        if (steps_seen == 0) step_cyc = cyc;
        steps_seen++;
      end
      if (dump_done) begin
        if (dones_seen == 0) done_cyc = cyc;
        dones_seen++;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_stall) fifo_full = ($urandom_range(0, 2) == 0);
    end
  end

  // driver tasks
  task automatic clear_tracking();
    pushes = 0; steps_seen = 0; dones_seen = 0;
    first_push_cyc = -1; step_cyc = -1; done_cyc = -1;
  endtask

  task automatic strobe(input logic [7:0] b, output int sampled_cyc);
    @(posedge clk); #1;
    rx_data = b; rx_data_rdy = 1'b1;
    @(posedge clk); #1;
    rx_data_rdy = 1'b0;
    rx_data = 8'($urandom);
    sampled_cyc = cyc;
  endtask

  task automatic expect_dump(input bit is_step);
    if (is_step) steps_model++;
    if (HDR > 0) begin
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'(steps_model));
    end
    for (int w = 0; w < NW; w++)
      for (int b = 0; b < 4; b++)
        exp_q.push_back(mem[w][8*b +: 8]);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (dones_seen == 0 && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    check("done_in_budget", 32'(dones_seen > 0), 32'd1);
    @(posedge clk); #1;
    check("busy_after_done", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_dump(input bit is_step, input bit timed, input int stall_cyc, input int c0);
    check("bytes_pushed", 32'(pushes), 32'(4*NW + HDR));
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("step_pulses", 32'(steps_seen), 32'(is_step));
    check("done_pulses", 32'(dones_seen), 32'd1);
    check("word_sel_hold", 32'(word_sel), 32'(NW - 1));
    if (timed) begin
      if (is_step) check("step_cycle", 32'(step_cyc), 32'(c0));
      check("first_push_cycle", 32'(first_push_cyc), 32'(c0 + (is_step ? SC + 1 : 0) + PUSH_OFS));
      check("done_cycle", 32'(done_cyc), 32'(first_push_cyc + LOAD_OFS + 5*NW + stall_cyc));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_step_en"}, 32'(step_en), 32'd0);
    check({tag, "_fifo_wr_en"}, 32'(fifo_wr_en), 32'd0);
    check({tag, "_fifo_din"}, 32'(fifo_din), 32'd0);
    check({tag, "_word_sel"}, 32'(word_sel), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_dump_done"}, 32'(dump_done), 32'd0);
  endtask

  task automatic wait_pushes_at_posedge(input int target, input int budget);
    int n = 0;
    while (pushes != target && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("reach_push_count", 32'(pushes), 32'(target));
  endtask

  initial begin
    int c0, cj;
    bit is_step, stalled;
    logic [7:0] junk;

    rst_n = 1'b0; rx_data = 8'h00; rx_data_rdy = 1'b0; fifo_full = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h11223300 + 32'(i);
    clear_tracking();
    #1;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;

    // 'S' with the directed word pattern
    clear_tracking(); expect_dump(1'b1);
    check("first_bytes", {exp_q[3+HDR], exp_q[2+HDR], exp_q[1+HDR], exp_q[HDR]}, 32'h11223300);
    strobe(8'h53, c0);
    wait_done(2000);
    check_dump(1'b1, 1'b1, 0, c0);

    // 'D': dump without a step
    clear_tracking(); expect_dump(1'b0);
    strobe(8'h44, c0);
    wait_done(2000);
    check_dump(1'b0, 1'b1, 0, c0);

    // FIFO full for 10 cycles while byte 2 of word 5 is offered
    clear_tracking(); expect_dump(1'b0);
    strobe(8'h44, c0);
    wait_pushes_at_posedge(HDR + 22, 400);
    fifo_full = 1'b1;
    repeat (10) @(posedge clk);
    #1; fifo_full = 1'b0;
    wait_done(2000);
    check_dump(1'b0, 1'b1, 10, c0);

    // unknown byte is ignored; strobes while busy are dropped
    clear_tracking();
    strobe(8'h58, c0);
    repeat (5) @(posedge clk);
    #1;
    check("ignored_busy", 32'(busy), 32'd0);
    check("ignored_pushes", 32'(pushes), 32'd0);
    check("ignored_steps", 32'(steps_seen), 32'd0);
    expect_dump(1'b1);
    strobe(8'h53, c0);
    strobe(8'h53, cj);
    repeat (20) @(posedge clk);
    strobe(8'h44, cj);
    wait_done(2000);
    check_dump(1'b1, 1'b1, 0, c0);

    // asynchronous reset during word 10
    clear_tracking(); expect_dump(1'b0);
    strobe(8'h44, c0);
    wait_pushes_at_posedge(HDR + 40, 400);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    exp_q.delete();
    steps_model = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    clear_tracking(); expect_dump(1'b0);
    strobe(8'h44, c0);
    wait_done(2000);
    check_dump(1'b0, 1'b1, 0, c0);

    // randomized commands, data, stalls and junk strobes while busy
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < 64; i++) mem[i] = $urandom;
      is_step = ($urandom_range(0, 1) == 1);
      stalled = ($urandom_range(0, 1) == 1);
      do junk = 8'($urandom); while (junk == 8'h53 || junk == 8'h44);
      clear_tracking();
      strobe(junk, cj);
      repeat ($urandom_range(1, 4)) @(posedge clk);
      #1;
      check("rand_junk_idle", 32'(busy), 32'd0);
      expect_dump(is_step);
      rand_stall = stalled;
      strobe(is_step ? 8'h53 : 8'h44, c0);
      repeat ($urandom_range(0, 30)) @(posedge clk);
      strobe(($urandom_range(0, 1) == 1) ? 8'h53 : 8'h44, cj);
      wait_done(3000);
      rand_stall = 1'b0;
      fifo_full = 1'b0;
      check_dump(is_step, !stalled, 0, c0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
